// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network datapath blocks.
// Contents: default lane count and width, the signed lane type, the
// bias-add sequencer state encoding and the signed saturation limits.
package nn_pkg;

  localparam int N_LANES_DEF = 10;
  localparam int DATA_W_DEF  = 32;

  typedef logic signed [DATA_W_DEF-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } bias_seq_state_t;

  // Clamp limits for a default-width lane.
  localparam lane_t LANE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam lane_t LANE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/bias_add_sequencer_bias_bank.sv
// Bias register file: N_LAYERS rows of N_LANES signed words.
// Latency: write lands at the next clock edge; read is combinational.
// Backpressure: none, the caller qualifies the write strobe.
// Ports: clk/rst (sync, active-high, clears every entry), we/wr_layer/wr_idx/
//   wr_data write port, rd_layer/rd_idx/rd_data read port. A read outside the
//   populated rows or lanes returns 0, which is how an out-of-range layer gets
//   a zero bias.
module bias_bank #(
  parameter int N_LAYERS = 4,
  parameter int N_LANES  = 10,
  parameter int DATA_W   = 32,
  localparam int LW = $clog2(N_LAYERS),
  localparam int IW = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [LW-1:0]            wr_layer,
  input  logic [IW-1:0]            wr_idx,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [LW-1:0]            rd_layer,
  input  logic [IW-1:0]            rd_idx,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [N_LAYERS][N_LANES];
  logic                     rd_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < N_LAYERS; l++) begin
        for (int i = 0; i < N_LANES; i++) begin
          mem[l][i] <= '0;
        end
      end
    end else if (we) begin
      mem[wr_layer][wr_idx] <= wr_data;
    end
  end

  assign rd_in_range = (int'(rd_layer) < N_LAYERS) && (int'(rd_idx) < N_LANES);
  assign rd_data     = rd_in_range ? mem[rd_layer][rd_idx] : '0;

endmodule

// File: rtl/bias_add_sequencer.sv
// Adds a per-layer bias to every lane of a vector using one shared adder, one lane per cycle.
// Latency: handshake in cycle T gives out_valid from cycle T+N_LANES+1; one vector in flight.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
// Ports: clk, rst (sync active-high); bias_we/bias_layer/bias_idx/bias_wdata bias
//   bank write; in_valid/in_ready/in_layer/in_data input vector; out_valid/
//   out_ready/out_data result vector; busy (not IDLE); bias_wr_err (1-cycle
//   pulse after a rejected bias write).
module bias_add_sequencer
  import nn_pkg::*;
#(
  parameter int N_LANES  = N_LANES_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_LAYERS = 4,
  parameter int SATURATE = 0,
  localparam int LW = $clog2(N_LAYERS),
  localparam int IW = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bias_we,
  input  logic [LW-1:0]            bias_layer,
  input  logic [IW-1:0]            bias_idx,
  input  logic signed [DATA_W-1:0] bias_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LW-1:0]            in_layer,
  input  logic signed [DATA_W-1:0] in_data [N_LANES],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data [N_LANES],
  output logic                     busy,
  output logic                     bias_wr_err
);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  bias_seq_state_t          state;
  logic [IW-1:0]            cnt;
  logic [LW-1:0]            layer_lat;
  logic signed [DATA_W-1:0] in_lat [N_LANES];

  logic signed [DATA_W-1:0] bias_rd;
  logic signed [DATA_W-1:0] lane_in;
  logic signed [DATA_W-1:0] lane_res;
  logic        [DATA_W:0]   sum_ext;
  logic                     accept;
  logic                     last_lane;
  logic                     wr_range_bad;
  logic                     wr_conflict;
  logic                     wr_ok;

  // in_ready is gated by rst so upstream never sees a handshake during reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_lane = (int'(cnt) == N_LANES - 1);

  // A write to the row being consumed would tear the vector, so it is refused.
  assign wr_range_bad = (int'(bias_layer) >= N_LAYERS) || (int'(bias_idx) >= N_LANES);
  assign wr_conflict  = busy && (bias_layer == layer_lat);
  assign wr_ok        = bias_we && !wr_range_bad && !wr_conflict;

  bias_bank #(
    .N_LAYERS (N_LAYERS),
    .N_LANES  (N_LANES),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_ok),
    .wr_layer (bias_layer),
    .wr_idx   (bias_idx),
    .wr_data  (bias_wdata),
    .rd_layer (layer_lat),
    .rd_idx   (cnt),
    .rd_data  (bias_rd)
  );

  // One extra bit of sum exposes signed overflow: top two bits disagree.
  assign lane_in = in_lat[cnt];
  assign sum_ext = {lane_in[DATA_W-1], lane_in} + {bias_rd[DATA_W-1], bias_rd};

  always_comb begin
    lane_res = sum_ext[DATA_W-1:0];
    if ((SATURATE != 0) && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
      lane_res = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      layer_lat   <= '0;
      bias_wr_err <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        in_lat[i]   <= '0;
        out_data[i] <= '0;
      end
    end else begin
      bias_wr_err <= bias_we && (wr_range_bad || wr_conflict);
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < N_LANES; i++) begin
              in_lat[i] <= in_data[i];
            end
            layer_lat <= in_layer;
            cnt       <= '0;
            state     <= ADD;
          end
        end
        ADD: begin
          out_data[cnt] <= lane_res;
          if (last_lane) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_add_sequencer.sv
// Bench for bias_add_sequencer: a wrap-around instance (4 layers) and a
// saturating instance (3 layers) share every input and run in lockstep.
// Ports: none.
`timescale 1ns/1ps
module tb_bias_add_sequencer;
  import nn_pkg::*;

  localparam int NL = 10;
  typedef logic [NL-1:0][31:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bias_we = 1'b0;
  logic [1:0] bias_layer = '0;
  logic [3:0] bias_idx = '0;
  lane_t      bias_wdata = '0;
  logic       in_valid = 1'b0;
  logic [1:0] in_layer = '0;
  lane_t      in_data [NL];
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, busy, bias_wr_err;
  lane_t      out_data [NL];
  logic       in_ready_s, out_valid_s, busy_s, bias_wr_err_s;
  lane_t      out_data_s [NL];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;
  vec_t exp0_q [$];
  vec_t exp1_q [$];
  int   due_q  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bias_add_sequencer #(.N_LAYERS(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst),
    .bias_we(bias_we), .bias_layer(bias_layer), .bias_idx(bias_idx), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_layer(in_layer), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .bias_wr_err(bias_wr_err)
  );

  bias_add_sequencer #(.N_LAYERS(3), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst),
    .bias_we(bias_we), .bias_layer(bias_layer), .bias_idx(bias_idx), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_layer(in_layer), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .busy(busy_s), .bias_wr_err(bias_wr_err_s)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic vec_t pk(input lane_t a [NL]);
    vec_t v;
    for (int i = 0; i < NL; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3, input int a4,
                              input int a5, input int a6, input int a7, input int a8, input int a9);
    return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Scoreboard monitor: latency on the first valid cycle, data on every valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid || out_valid_s) begin
      if (exp0_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: out_valid=%b out_valid_s=%b, scoreboard empty", out_valid, out_valid_s);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency_cycle", cyc, due_q[0]);
          chkb("out_valid", out_valid, 1'b1);
          chkb("out_valid_s", out_valid_s, 1'b1);
        end
        chkv("out_data", pk(out_data), exp0_q[0]);
        chkv("out_data_s", pk(out_data_s), exp1_q[0]);
        if (out_ready) begin
          void'(exp0_q.pop_front());
          void'(exp1_q.pop_front());
          void'(due_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Enter at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input vec_t d, input logic [1:0] layer, input vec_t e0, input vec_t e1);
    int w = 0;
    for (int i = 0; i < NL; i++) in_data[i] = d[i];
    in_layer = layer;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chkb("send_in_ready", in_ready, 1'b1);
    if (in_ready) begin
      chkb("send_in_ready_s", in_ready_s, 1'b1);
      exp0_q.push_back(e0);
      exp1_q.push_back(e1);
      due_q.push_back(cyc + NL + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic bwrite(input logic [1:0] l, input logic [3:0] ix, input int v,
                        input logic e0, input logic e1);
    bias_we    = 1'b1;
    bias_layer = l;
    bias_idx   = ix;
    bias_wdata = v;
    @(posedge clk);
    #1;
    bias_we = 1'b0;
    chkb("bias_wr_err", bias_wr_err, e0);
    chkb("bias_wr_err_s", bias_wr_err_s, e1);
    @(posedge clk);
    #1;
    chkb("bias_wr_err_pulse", bias_wr_err, 1'b0);
    chkb("bias_wr_err_pulse_s", bias_wr_err_s, 1'b0);
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chkb("wait_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    for (int i = 0; i < NL; i++) in_data[i] = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("in_ready_in_reset", in_ready, 1'b0);
    chkb("in_ready_in_reset_s", in_ready_s, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_bias_wr_err", bias_wr_err, 1'b0);
    chkv("rst_out_data", pk(out_data), '0);
    chkb("rst_in_ready_s", in_ready_s, 1'b1);
    @(posedge clk);
    #1;

    // 1: bank[1] = 1..10, data 100..109
    for (int i = 0; i < NL; i++) bwrite(2'd1, 4'(i), i + 1, 1'b0, 1'b0);
    send(mk(100, 101, 102, 103, 104, 105, 106, 107, 108, 109), 2'd1,
         mk(101, 103, 105, 107, 109, 111, 113, 115, 117, 119),
         mk(101, 103, 105, 107, 109, 111, 113, 115, 117, 119));

    // 2: overflow in both directions on layer 0
    bwrite(2'd0, 4'd0, 1, 1'b0, 1'b0);
    bwrite(2'd0, 4'd1, -1, 1'b0, 1'b0);
    bwrite(2'd0, 4'd2, -7, 1'b0, 1'b0);
    send(mk(32'h7FFF_FFFF, 32'h8000_0000, 3, 3000, 4000, 5000, 6000, 7000, 8000, 9000), 2'd0,
         mk(32'h8000_0000, 32'h7FFF_FFFF, -4, 3000, 4000, 5000, 6000, 7000, 8000, 9000),
         mk(32'h7FFF_FFFF, 32'h8000_0000, -4, 3000, 4000, 5000, 6000, 7000, 8000, 9000));

    // 3: stall in HOLD while a second vector waits
    send(mk(-50, -30, -10, 10, 30, 50, 70, 90, 110, 130), 2'd0,
         mk(-49, -31, -17, 10, 30, 50, 70, 90, 110, 130),
         mk(-49, -31, -17, 10, 30, 50, 70, 90, 110, 130));
    out_ready = 1'b0;
    fork
      send(mk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 2'd1,
           mk(1, 3, 5, 7, 9, 11, 13, 15, 17, 19),
           mk(1, 3, 5, 7, 9, 11, 13, 15, 17, 19));
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 40) begin
          @(negedge clk);
          w++;
        end
        chkb("hold_reached", out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chkb("hold_in_ready", in_ready, 1'b0);
          chkb("hold_busy", busy, 1'b1);
          chkb("hold_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // 4: writes while layer 2 is being processed
    bwrite(2'd2, 4'd3, 5, 1'b0, 1'b0);
    send(mk(10, 10, 10, 10, 10, 10, 10, 10, 10, 10), 2'd2,
         mk(10, 10, 10, 15, 10, 10, 10, 10, 10, 10),
         mk(10, 10, 10, 15, 10, 10, 10, 10, 10, 10));
    bwrite(2'd2, 4'd3, 77, 1'b1, 1'b1);
    bwrite(2'd3, 4'd0, 1000, 1'b0, 1'b1);
    bwrite(2'd0, 4'd12, 9, 1'b1, 1'b1);

    // 6: layer 3 is valid for the 4-layer instance, out of range for the 3-layer one
    send(mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), 2'd3,
         mk(1001, 2, 3, 4, 5, 6, 7, 8, 9, 10),
         mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb("oor_layer_no_err", bias_wr_err, 1'b0);
      chkb("oor_layer_no_err_s", bias_wr_err_s, 1'b0);
    end
    @(posedge clk);
    #1;

    // Handshake and bias write to the same row in the same cycle
    wait_idle();
    bias_we    = 1'b1;
    bias_layer = 2'd0;
    bias_idx   = 4'd5;
    bias_wdata = 500;
    send(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0,
         mk(1, -1, -7, 0, 0, 500, 0, 0, 0, 0),
         mk(1, -1, -7, 0, 0, 500, 0, 0, 0, 0));
    bias_we = 1'b0;
    chkb("same_cycle_wr_err", bias_wr_err, 1'b0);
    chkb("same_cycle_wr_err_s", bias_wr_err_s, 1'b0);

    // 5: reset at lane 4 of ADD
    send(mk(100, 101, 102, 103, 104, 105, 106, 107, 108, 109), 2'd1, '0, '0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    due_q.delete();
    @(negedge clk);
    chkb("midrst_in_ready", in_ready, 1'b1);
    chkb("midrst_out_valid", out_valid, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkv("midrst_out_data", pk(out_data), '0);
    chkv("midrst_out_data_s", pk(out_data_s), '0);
    nz = 0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < NL; i++)
        if (dut.u_bank.mem[l][i] !== '0) nz++;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < NL; i++)
        if (dut_s.u_bank.mem[l][i] !== '0) nz++;
    chk("midrst_bank_nonzero_entries", nz, 0);
    @(posedge clk);
    #1;
    send(mk(100, 101, 102, 103, 104, 105, 106, 107, 108, 109), 2'd1,
         mk(100, 101, 102, 103, 104, 105, 106, 107, 108, 109),
         mk(100, 101, 102, 103, 104, 105, 106, 107, 108, 109));

    // Drain the scoreboard
    begin
      int w = 0;
      while (exp0_q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("scoreboard_drained", exp0_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
